// File: rtl/cdb_arbiter.sv
// Writeback arbiter: three private result FIFOs (ALU, load, branch) drained one entry per cycle onto the CDB.
// Optional build macro CDB_ARB_FIXED_PRIO_EN selects fixed priority BRANCH > LOAD > ALU instead of round-robin.
module cdb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int PHY_WIDTH  = 6,
    parameter int ROB_WIDTH  = 5,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alu_valid,
    input  logic [ROB_WIDTH-1:0]  alu_rob_id,
    input  logic [PHY_WIDTH-1:0]  rd_phy_alu,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  load_valid,
    input  logic [ROB_WIDTH-1:0]  load_rob_id,
    input  logic [PHY_WIDTH-1:0]  load_rd_phy,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  branch_valid,
    input  logic [ROB_WIDTH-1:0]  branch_rob_id,
    input  logic [PHY_WIDTH-1:0]  rd_phy_branch,
    input  logic [DATA_WIDTH-1:0] nextPC,
    input  logic                  isJump,
    output logic                  busy_alu,
    output logic                  busy_lsu,
    output logic                  busy_branch,
    output logic                  cdb_valid,
    output logic [1:0]            cdb_src,
    output logic [ROB_WIDTH-1:0]  cdb_rob_id,
    output logic [PHY_WIDTH-1:0]  cdb_rd_phy,
    output logic [DATA_WIDTH-1:0] cdb_data,
    output logic                  cdb_wen,
    output logic                  overflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    // Storage is not reset: the CDB outputs are forced to zero whenever no FIFO holds data.
    logic [ROB_WIDTH-1:0]  rob_mem  [0:2][0:DEPTH-1];
    logic [PHY_WIDTH-1:0]  phy_mem  [0:2][0:DEPTH-1];
    logic [DATA_WIDTH-1:0] data_mem [0:2][0:DEPTH-1];
    logic                  wen_mem  [0:2][0:DEPTH-1];

    logic [PTR_W-1:0] rd_ptr [0:2];
    logic [PTR_W-1:0] wr_ptr [0:2];
    logic [CNT_W-1:0] count  [0:2];

    logic [2:0]            push_v;
    logic [2:0]            push_ok;
    logic [2:0]            pop;
    logic [2:0]            busy;
    logic [2:0]            non_empty;
    logic [ROB_WIDTH-1:0]  push_rob  [0:2];
    logic [PHY_WIDTH-1:0]  push_phy  [0:2];
    logic [DATA_WIDTH-1:0] push_data [0:2];
    logic [2:0]            push_wen;
    logic                  grant;
    logic [1:0]            win;

    assign push_v       = {branch_valid, load_valid, alu_valid};
    assign push_wen     = {isJump, 1'b1, 1'b1};
    assign push_rob[0]  = alu_rob_id;
    assign push_rob[1]  = load_rob_id;
    assign push_rob[2]  = branch_rob_id;
    assign push_phy[0]  = rd_phy_alu;
    assign push_phy[1]  = load_rd_phy;
    assign push_phy[2]  = rd_phy_branch;
    assign push_data[0] = alu_result;
    assign push_data[1] = load_data;
    assign push_data[2] = nextPC;

    always_comb begin
        busy      = '0;
        non_empty = '0;
        for (int i = 0; i < 3; i++) begin
            busy[i]      = (count[i] == FULL);
            non_empty[i] = (count[i] != '0);
        end
    end

    assign busy_alu    = busy[0];
    assign busy_lsu    = busy[1];
    assign busy_branch = busy[2];

    // A full FIFO refuses the push even if it pops in the same cycle.
    assign push_ok = push_v & ~busy;
    assign pop     = grant ? (3'b001 << win) : 3'b000;

`ifdef CDB_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = 1'b1;
        win   = 2'd0;
        if (non_empty[2])      win = 2'd2;
        else if (non_empty[1]) win = 2'd1;
        else if (non_empty[0]) win = 2'd0;
        else                   grant = 1'b0;
    end
`else
    logic [1:0] rr_ptr;
    logic [1:0] scan [0:2];

    // Scan from the lowest priority upward so the last hit is the winner.
    always_comb begin
        scan[0] = rr_ptr;
        scan[1] = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
        scan[2] = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
        grant   = 1'b0;
        win     = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (non_empty[scan[k]]) begin
                grant = 1'b1;
                win   = scan[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (flush) begin
            rr_ptr <= 2'd0;
        end else if (grant) begin
            rr_ptr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
        end
    end
`endif

    always_comb begin
        cdb_valid  = grant;
        cdb_src    = '0;
        cdb_rob_id = '0;
        cdb_rd_phy = '0;
        cdb_data   = '0;
        cdb_wen    = 1'b0;
        if (grant) begin
            cdb_src    = win;
            cdb_rob_id = rob_mem[win][rd_ptr[win]];
            cdb_rd_phy = phy_mem[win][rd_ptr[win]];
            cdb_data   = data_mem[win][rd_ptr[win]];
            cdb_wen    = wen_mem[win][rd_ptr[win]];
        end
    end

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push_ok[i] && !flush) begin
                rob_mem[i][wr_ptr[i]]  <= push_rob[i];
                phy_mem[i][wr_ptr[i]]  <= push_phy[i];
                data_mem[i][wr_ptr[i]] <= push_data[i];
                wen_mem[i][wr_ptr[i]]  <= push_wen[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else if (flush) begin
            // Flush-cycle pushes vanish silently; the sticky error is kept.
            for (int i = 0; i < 3; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push_v[i] && busy[i]) overflow_err <= 1'b1;
                if (push_ok[i]) wr_ptr[i] <= bump(wr_ptr[i]);
                if (pop[i])     rd_ptr[i] <= bump(rd_ptr[i]);
                if (push_ok[i] && !pop[i])
                    count[i] <= count[i] + 1'b1;
                else if (!push_ok[i] && pop[i])
                    count[i] <= count[i] - 1'b1;
            end
        end
    end

endmodule
